// File: rtl/main_ram_pkg.sv
// Shared types and sizing for the main-RAM DRAM-socket adapter.
// Holds the FSM state encoding, bus widths and the legal read-latency range.
package main_ram_pkg;

  localparam int RA_W   = 8;
  localparam int MEM_AW = 16;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef enum logic [1:0] {
    IDLE,
    ROW,
    ACCESS,
    HOLD
  } state_e;

endpackage

// File: rtl/dram_strobe_sync.sv
// Strobe conditioner: optional two-flop synchroniser (DRAM_SYNC_EN) plus edge detector.
// Latency: fall/rise pulses in the cycle the conditioned level changes; +2 cycles with DRAM_SYNC_EN.
// No backpressure: pulses last one cycle and must be consumed when they appear.
module dram_strobe_sync (
  input  logic clk_core,
  input  logic reset,
  input  logic strobe_n,
  output logic level_n,
  output logic fall,
  output logic rise
);

  logic prev_n;

`ifdef DRAM_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], strobe_n};
    end
  end

  assign level_n = sync_q[1];
`else
  assign level_n = strobe_n;
`endif

  // Strobes idle high, so reset the history high to avoid a false edge.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      prev_n <= 1'b1;
    end else begin
      prev_n <= level_n;
    end
  end

  assign fall = prev_n & ~level_n;
  assign rise = ~prev_n & level_n;

endmodule

// File: rtl/main_ram_dram_adapter.sv
// DRAM socket (RA/RAS/CAS/RW) to single-port synchronous RAM bridge; DRAM_SYNC_EN adds input synchronisers.
// Latency: mem_en one cycle after CAS-fall detection, d_out/d_oe READ_LATENCY+1 cycles after mem_en.
// No backpressure: the socket master owns timing; CAS must stay low READ_LATENCY+3 cycles per access.
module main_ram_dram_adapter
  import main_ram_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic              clk_core,
  input  logic              reset,
  input  logic [RA_W-1:0]   ra,
  input  logic              ras_n,
  input  logic              cas_n,
  input  logic              rw_n,
  input  logic [RA_W-1:0]   d_in,
  output logic [RA_W-1:0]   d_out,
  output logic              d_oe,
  output logic [MEM_AW-1:0] mem_a,
  output logic              mem_en,
  output logic              mem_we,
  output logic [RA_W-1:0]   mem_wd,
  input  logic [RA_W-1:0]   mem_rd,
  output logic              refresh_pulse,
  output logic              proto_err
);

  localparam int RL = (READ_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                      (READ_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : READ_LATENCY;
  localparam logic [1:0] RL_CNT = 2'(RL);

  logic            ras_lvl_n, ras_fall, ras_rise;
  logic            cas_lvl_n, cas_fall, cas_rise;
  logic            unused_cas_lvl;
  logic [RA_W-1:0] ra_s, d_s;
  logic            rw_s;

  state_e          state;
  logic [RA_W-1:0] row_q, col_q;
  logic            rd_q;
  logic            cas_seen;
  logic [1:0]      lat_cnt;
  logic            start_acc;

  dram_strobe_sync u_ras_sync (
    .clk_core (clk_core),
    .reset    (reset),
    .strobe_n (ras_n),
    .level_n  (ras_lvl_n),
    .fall     (ras_fall),
    .rise     (ras_rise)
  );

  dram_strobe_sync u_cas_sync (
    .clk_core (clk_core),
    .reset    (reset),
    .strobe_n (cas_n),
    .level_n  (cas_lvl_n),
    .fall     (cas_fall),
    .rise     (cas_rise)
  );

  assign unused_cas_lvl = cas_lvl_n;

`ifdef DRAM_SYNC_EN
  logic [RA_W-1:0] ra_m, d_m;
  logic            rw_m;

  // Same two-stage delay as the strobes so address/data line up with the edge pulses.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      ra_m <= '0;
      d_m  <= '0;
      rw_m <= 1'b1;
      ra_s <= '0;
      d_s  <= '0;
      rw_s <= 1'b1;
    end else begin
      ra_m <= ra;
      d_m  <= d_in;
      rw_m <= rw_n;
      ra_s <= ra_m;
      d_s  <= d_m;
      rw_s <= rw_m;
    end
  end
`else
  assign ra_s = ra;
  assign d_s  = d_in;
  assign rw_s = rw_n;
`endif

  // A RAS fall coincident with a CAS fall counts as RAS-then-CAS.
  assign start_acc = cas_fall && ((state == IDLE && ras_fall) || (state == ROW && !ras_rise));

  assign mem_a = {col_q, row_q};

  always_ff @(posedge clk_core) begin
    if (reset) begin
      state         <= IDLE;
      row_q         <= '0;
      col_q         <= '0;
      rd_q          <= 1'b0;
      cas_seen      <= 1'b0;
      lat_cnt       <= '0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_wd        <= '0;
      d_out         <= '0;
      d_oe          <= 1'b0;
      refresh_pulse <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      refresh_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (ras_fall) begin
            row_q    <= ra_s;
            cas_seen <= 1'b0;
            state    <= cas_fall ? ACCESS : ROW;
          end else if (cas_fall) begin
            proto_err <= 1'b1;
          end
        end

        ROW: begin
          if (ras_rise) begin
            refresh_pulse <= ~cas_seen;
            state         <= IDLE;
          end else if (cas_fall) begin
            state <= ACCESS;
          end
        end

        ACCESS: begin
          if (ras_rise) begin
            d_oe  <= 1'b0;
            state <= IDLE;
          end else if (cas_rise) begin
            state <= ras_lvl_n ? IDLE : ROW;
          end else if (!rd_q) begin
            state <= HOLD;
          end else if (lat_cnt == RL_CNT) begin
            d_out <= mem_rd;
            d_oe  <= 1'b1;
            state <= HOLD;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        HOLD: begin
          if (ras_rise) begin
            d_oe  <= 1'b0;
            state <= IDLE;
          end else if (cas_rise) begin
            d_oe  <= 1'b0;
            state <= ras_lvl_n ? IDLE : ROW;
          end
        end

        default: state <= IDLE;
      endcase

      // Placed after the case so it overrides the cas_seen clear on a coincident RAS fall.
      if (start_acc) begin
        col_q    <= ra_s;
        rd_q     <= rw_s;
        mem_wd   <= d_s;
        mem_en   <= 1'b1;
        mem_we   <= ~rw_s;
        lat_cnt  <= '0;
        cas_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_main_ram_dram_adapter.sv
// Drives one socket stimulus into READ_LATENCY=1 and =2 adapters side by side.
// Expected values come from a behavioural memory image and the socket timing rules.
module tb_main_ram_dram_adapter;

  logic clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  logic       reset;
  logic [7:0] ra, d_in;
  logic       ras_n, cas_n, rw_n;

  logic [7:0]  d_out  [2];
  logic [15:0] mem_a  [2];
  logic [7:0]  mem_wd [2];
  logic [1:0]  d_oe, mem_en, mem_we, rfp, perr;
  logic [7:0]  rd_rl1, rd_rl2_a, rd_rl2_b;

  logic [7:0] sram    [logic [15:0]];
  logic [7:0] ref_mem [logic [15:0]];

  int checks = 0;
  int errors = 0;
  int en_cnt[2], we_cnt[2], rf_cnt[2], oe_cnt[2], stray_we[2];
  logic [15:0] last_a[2];
  logic [7:0]  last_wd[2];

  main_ram_dram_adapter #(.READ_LATENCY(1)) u_rl1 (
    .clk_core(clk_core), .reset(reset), .ra(ra), .ras_n(ras_n), .cas_n(cas_n),
    .rw_n(rw_n), .d_in(d_in), .d_out(d_out[0]), .d_oe(d_oe[0]), .mem_a(mem_a[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_wd(mem_wd[0]), .mem_rd(rd_rl1),
    .refresh_pulse(rfp[0]), .proto_err(perr[0])
  );

  main_ram_dram_adapter #(.READ_LATENCY(2)) u_rl2 (
    .clk_core(clk_core), .reset(reset), .ra(ra), .ras_n(ras_n), .cas_n(cas_n),
    .rw_n(rw_n), .d_in(d_in), .d_out(d_out[1]), .d_oe(d_oe[1]), .mem_a(mem_a[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_wd(mem_wd[1]), .mem_rd(rd_rl2_b),
    .refresh_pulse(rfp[1]), .proto_err(perr[1])
  );

  // Unwritten locations hold a fixed address-derived pattern; 16'h1234 reads as 8'hA5.
  function automatic logic [7:0] fill(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h83;
  endfunction

  function automatic logic [7:0] sram_rd(input logic [15:0] a);
    return sram.exists(a) ? sram[a] : fill(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  always @(posedge clk_core) begin
    rd_rl1   <= sram_rd(mem_a[0]);
    rd_rl2_a <= sram_rd(mem_a[1]);
    rd_rl2_b <= rd_rl2_a;
    if (mem_en[0] && mem_we[0]) sram[mem_a[0]] = mem_wd[0];
    if (mem_en[1] && mem_we[1]) sram[mem_a[1]] = mem_wd[1];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input string base, input int k);
    return $sformatf("%s[rl%0d]", base, k + 1);
  endfunction

  task automatic tick();
    @(negedge clk_core);
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k]) begin
        en_cnt[k]++;
        last_a[k] = mem_a[k];
        if (mem_we[k]) begin
          we_cnt[k]++;
          last_wd[k] = mem_wd[k];
        end
      end else if (mem_we[k]) begin
        stray_we[k]++;
      end
      if (rfp[k]) rf_cnt[k]++;
      if (d_oe[k]) oe_cnt[k]++;
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk(tg({tag, "_dout"}, k), int'(d_out[k]), 0);
      chk(tg({tag, "_doe"}, k), int'(d_oe[k]), 0);
      chk(tg({tag, "_mema"}, k), int'(mem_a[k]), 0);
      chk(tg({tag, "_memen"}, k), int'(mem_en[k]), 0);
      chk(tg({tag, "_memwe"}, k), int'(mem_we[k]), 0);
      chk(tg({tag, "_memwd"}, k), int'(mem_wd[k]), 0);
      chk(tg({tag, "_refresh"}, k), int'(rfp[k]), 0);
      chk(tg({tag, "_proto"}, k), int'(perr[k]), 0);
    end
  endtask

  task automatic ras_open(input logic [7:0] row);
    ra    = row;
    ras_n = 1'b0;
    tick();
    tick();
  endtask

  task automatic ras_close();
    ras_n = 1'b1;
    tick();
    tick();
  endtask

  // One CAS pulse; read data must show up exactly READ_LATENCY+2 samples after the fall.
  task automatic cas_cycle(input logic [7:0] col, input logic rw, input logic [7:0] d,
                           input int hold, input logic [7:0] row, input logic [7:0] exp_rd,
                           input string tag);
    int e0[2], w0[2], first_oe[2];
    logic [15:0] a;
    a = {col, row};
    for (int k = 0; k < 2; k++) begin
      e0[k] = en_cnt[k];
      w0[k] = we_cnt[k];
      first_oe[k] = -1;
    end
    ra    = col;
    rw_n  = rw;
    d_in  = d;
    cas_n = 1'b0;
    for (int c = 1; c <= hold; c++) begin
      tick();
      for (int k = 0; k < 2; k++)
        if (d_oe[k] && first_oe[k] < 0) first_oe[k] = c;
    end
    for (int k = 0; k < 2; k++) begin
      chk(tg({tag, "_addr"}, k), int'(last_a[k]), int'(a));
      chk(tg({tag, "_en_pulses"}, k), en_cnt[k] - e0[k], 1);
      if (!rw) begin
        chk(tg({tag, "_we_pulses"}, k), we_cnt[k] - w0[k], 1);
        chk(tg({tag, "_wd"}, k), int'(last_wd[k]), int'(d));
        chk(tg({tag, "_doe_never"}, k), first_oe[k], -1);
      end else begin
        chk(tg({tag, "_we_pulses"}, k), we_cnt[k] - w0[k], 0);
        chk(tg({tag, "_doe_cycle"}, k), first_oe[k], k + 3);
        chk(tg({tag, "_dout"}, k), int'(d_out[k]), int'(exp_rd));
        chk(tg({tag, "_doe_held"}, k), int'(d_oe[k]), 1);
      end
    end
    cas_n = 1'b1;
    rw_n  = 1'b1;
    tick();
    for (int k = 0; k < 2; k++)
      chk(tg({tag, "_doe_clear"}, k), int'(d_oe[k]), 0);
    if (!rw) ref_mem[a] = d;
  endtask

  int e_snap[2], o_snap[2], r_snap[2];
  logic [7:0] row, col, dat;
  logic       rw;
  int         ncas;

  initial begin
    reset = 1'b1;
    ras_n = 1'b1;
    cas_n = 1'b1;
    rw_n  = 1'b1;
    ra    = 8'h00;
    d_in  = 8'h00;
    tick(); tick(); tick();
    check_reset("reset");
    reset = 1'b0;
    tick(); tick();

    // Read of a preloaded location.
    for (int k = 0; k < 2; k++) r_snap[k] = rf_cnt[k];
    ras_open(8'h34);
    cas_cycle(8'h12, 1'b1, 8'h00, 6, 8'h34, 8'hA5, "read");
    ras_close();

    // Early write, then read it back on a fresh RAS cycle.
    ras_open(8'h00);
    cas_cycle(8'hC0, 1'b0, 8'h5A, 6, 8'h00, 8'h00, "write");
    ras_close();
    ras_open(8'h00);
    cas_cycle(8'hC0, 1'b1, 8'h00, 6, 8'h00, 8'h5A, "readback");
    ras_close();

    // Page mode: three columns under one row.
    ras_open(8'h10);
    for (int i = 1; i <= 3; i++)
      cas_cycle(8'(i), 1'b1, 8'h00, 6, 8'h10, ref_rd({8'(i), 8'h10}), "page");
    ras_close();
    for (int k = 0; k < 2; k++)
      chk(tg("no_refresh_after_cas", k), rf_cnt[k] - r_snap[k], 0);

    // RAS-only refresh.
    for (int k = 0; k < 2; k++) begin
      r_snap[k] = rf_cnt[k];
      e_snap[k] = en_cnt[k];
    end
    ras_open(8'h7F);
    tick();
    ras_close();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk(tg("refresh_pulses", k), rf_cnt[k] - r_snap[k], 1);
      chk(tg("refresh_no_en", k), en_cnt[k] - e_snap[k], 0);
    end

    // RAS and CAS falling together act as RAS then CAS.
    ras_n = 1'b0;
    cas_cycle(8'h66, 1'b1, 8'h00, 6, 8'h66, ref_rd(16'h6666), "simul");
    ras_close();
    for (int k = 0; k < 2; k++)
      chk(tg("simul_proto", k), int'(perr[k]), 0);

    // Randomised traffic against the reference image.
    for (int t = 0; t < 30; t++) begin
      row = 8'($urandom);
      ras_open(row);
      ncas = $urandom_range(1, 3);
      for (int j = 0; j < ncas; j++) begin
        col = 8'($urandom);
        rw  = 1'($urandom_range(0, 1));
        dat = 8'($urandom);
        cas_cycle(col, rw, dat, $urandom_range(5, 8), row, ref_rd({col, row}), "rand");
      end
      ras_close();
    end

    // CAS fall with RAS high is a protocol error and is sticky.
    for (int k = 0; k < 2; k++) e_snap[k] = en_cnt[k];
    cas_n = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 2; k++) begin
      chk(tg("proto_set", k), int'(perr[k]), 1);
      chk(tg("proto_no_en", k), en_cnt[k] - e_snap[k], 0);
    end
    cas_n = 1'b1;
    tick(); tick();
    ras_open(8'h55);
    cas_cycle(8'hAA, 1'b1, 8'h00, 6, 8'h55, ref_rd(16'hAA55), "after_proto");
    ras_close();
    for (int k = 0; k < 2; k++)
      chk(tg("proto_sticky", k), int'(perr[k]), 1);

    // RAS rises while the read is still in flight: no data is presented.
    for (int k = 0; k < 2; k++) begin
      e_snap[k] = en_cnt[k];
      o_snap[k] = oe_cnt[k];
    end
    ras_open(8'h21);
    ra    = 8'h43;
    rw_n  = 1'b1;
    cas_n = 1'b0;
    tick(); tick();
    ras_n = 1'b1;
    tick();
    cas_n = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 2; k++) begin
      chk(tg("abort_en", k), en_cnt[k] - e_snap[k], 1);
      chk(tg("abort_doe_never", k), oe_cnt[k] - o_snap[k], 0);
    end

    // Reset in the middle of an access.
    ras_open(8'h99);
    ra    = 8'h88;
    rw_n  = 1'b0;
    d_in  = 8'h77;
    cas_n = 1'b0;
    tick();
    for (int k = 0; k < 2; k++)
      chk(tg("midrst_en_seen", k), int'(mem_en[k]), 1);
    ref_mem[16'h8899] = 8'h77;
    reset = 1'b1;
    ras_n = 1'b1;
    cas_n = 1'b1;
    rw_n  = 1'b1;
    tick();
    check_reset("midrst");
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) e_snap[k] = en_cnt[k];
    tick(); tick(); tick(); tick();
    for (int k = 0; k < 2; k++)
      chk(tg("post_reset_no_en", k), en_cnt[k] - e_snap[k], 0);

    ras_open(8'h99);
    cas_cycle(8'h88, 1'b1, 8'h00, 6, 8'h99, ref_rd(16'h8899), "post_reset");
    ras_close();

    for (int k = 0; k < 2; k++)
      chk(tg("stray_we", k), stray_we[k], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
